muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit; successor to the fixed 32-bit mul/div pair that sits beside the EX-stage ALU.
- Adds width/speed parameters, a unified op encoding, multiply-accumulate/subtract (MADD/MSUB), annul, and divide-by-zero flagging.
- The EX stage drives start_i and stalls the pipeline while busy_o is high.
- It writes result_o into HI/LO when ready_o pulses.

---
 rtl/muldiv_iter.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage.
// Multiply is shift-add retiring MUL_STEP multiplier bits per cycle, with optional
// accumulate/subtract against a captured HI/LO value. Divide is restoring division,
// one quotient bit per cycle. Signed operations run on magnitudes and the sign is
// applied on the edge that enters DONE.
module muldiv_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_zero_o
);

    localparam int unsigned MUL_ITERS = WIDTH / MUL_STEP;
    localparam int unsigned CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_ITERS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   hilo;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 acc;
    logic                 sub;
    logic                 neg;      // product / quotient must be negated
    logic                 rem_neg;  // remainder takes the dividend sign

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   mul_sum;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [2*WIDTH-1:0]   mul_final;
    logic [WIDTH-1:0]     trial;
    logic                 ge;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quot_nxt;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign busy_o = (state == MUL) || (state == DIV);

    // Operand magnitudes for signed ops, taken straight from the inputs at start.
    always_comb begin
        abs_a = (op_i[0] && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        abs_b = (op_i[0] && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    end

    // One shift-add step plus sign fix-up and accumulate for the final step.
    always_comb begin
        mul_sum = prod;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                mul_sum = mul_sum + (mcand << j);
            end
        end
        prod_signed = neg ? -mul_sum : mul_sum;
        if (acc) begin
            mul_final = sub ? (hilo - prod_signed) : (hilo + prod_signed);
        end else begin
            mul_final = prod_signed;
        end
    end

    // One restoring-division step; rem[WIDTH-1] set means the trial value exceeds
    // any WIDTH-bit divisor, so the subtraction is taken unconditionally.
    always_comb begin
        trial    = {rem[WIDTH-2:0], quot[WIDTH-1]};
        ge       = rem[WIDTH-1] || (trial >= divisor);
        rem_nxt  = ge ? (trial - divisor) : trial;
        quot_nxt = {quot[WIDTH-2:0], ge};
        quot_fix = neg ? -quot_nxt : quot_nxt;
        rem_fix  = rem_neg ? -rem_nxt : rem_nxt;
    end

    // Control FSM and datapath registers; ready_o is a one-cycle pulse into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hilo       <= '0;
            prod       <= '0;
            mcand      <= '0;
            mplier     <= '0;
            divisor    <= '0;
            quot       <= '0;
            rem        <= '0;
            acc        <= 1'b0;
            sub        <= 1'b0;
            neg        <= 1'b0;
            rem_neg    <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start_i && !annul_i) begin
                        cnt     <= '0;
                        hilo    <= hilo_i;
                        prod    <= '0;
                        mcand   <= {{WIDTH{1'b0}}, abs_a};
                        mplier  <= abs_b;
                        divisor <= abs_b;
                        quot    <= abs_a;
                        rem     <= '0;
                        acc     <= op_i[2];
                        sub     <= op_i[1];
                        neg     <= op_i[0] & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        rem_neg <= op_i[0] & opa_i[WIDTH-1];
                        if (op_i[2:1] == 2'b01) begin
                            if (opb_i == '0) begin
                                state      <= DONE;
                                ready_o    <= 1'b1;
                                result_o   <= {opa_i, {WIDTH{1'b1}}};
                                div_zero_o <= 1'b1;
                            end else begin
                                state <= DIV;
                            end
                        end else begin
                            state <= MUL;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        prod   <= mul_sum;
                        mcand  <= mcand << MUL_STEP;
                        mplier <= mplier >> MUL_STEP;
                        cnt    <= cnt + 1'b1;
                        if (cnt == MUL_LAST) begin
                            state      <= DONE;
                            ready_o    <= 1'b1;
                            result_o   <= mul_final;
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        rem  <= rem_nxt;
                        quot <= quot_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == DIV_LAST) begin
                            state      <= DONE;
                            ready_o    <= 1'b1;
                            result_o   <= {rem_fix, quot_fix};
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus randomized operations
// against an arithmetic reference model.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, start4;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i;
    logic [63:0] hilo_i;
    logic        annul_i;
    logic        busy_o, ready_o, div_zero_o;
    logic [63:0] result_o;
    logic        busy4, ready4, div_zero4;
    logic [63:0] result4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
        .hilo_i     (hilo_i),
        .annul_i    (annul_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .div_zero_o (div_zero_o)
    );

    muldiv_iter #(.WIDTH(32), .MUL_STEP(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start4),
        .op_i       (op_i),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
        .hilo_i     (hilo_i),
        .annul_i    (annul_i),
        .busy_o     (busy4),
        .ready_o    (ready4),
        .result_o   (result4),
        .div_zero_o (div_zero4)
    );

    // Reference: {div_zero, HI, LO} from plain signed/unsigned arithmetic.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
        if (op[2:1] == 2'b01) begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            return {1'b0, r, q};
        end
        p = 64'(sa * sb);
        if (op[2]) p = op[1] ? (h - p) : (h + p);
        return {1'b0, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one operation with a single-cycle start; inputs are scrambled after
    // the start edge, then latency, result, flag and pulse width are checked.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, input string tag);
        logic [64:0] exp;
        int          cyc;
        int          lat;
        exp = model(op, a, b, h);
        lat = (op[2:1] == 2'b01 && b == 32'd0) ? 1 : 33;
        @(negedge clk);
        op_i = op; opa_i = a; opb_i = b; hilo_i = h; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        opa_i = $urandom; opb_i = $urandom; hilo_i = {$urandom, $urandom};
        op_i = 3'($urandom);
        cyc = 1;
        if (lat > 1) chk({tag, " busy"}, 64'(busy_o), 64'd1);
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, result_o, exp[63:0]);
        chk({tag, " div_zero"}, 64'(div_zero_o), 64'(exp[64]));
        @(negedge clk);
        chk({tag, " ready pulse"}, 64'(ready_o), 64'd0);
        chk({tag, " result held"}, result_o, exp[63:0]);
    endtask

    initial begin
        logic [64:0] prev;
        logic [64:0] e;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] rh;
        int          cyc;
        int          nready;

        rst = 1'b1; start_i = 1'b0; start4 = 1'b0; annul_i = 1'b0;
        op_i = 3'd0; opa_i = '0; opb_i = '0; hilo_i = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset div_zero", 64'(div_zero_o), 64'd0);
        rst = 1'b0;

        // Directed cases from the operation list
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 64'd0, "MULT -2*3");
        chk("MULT -2*3 const", result_o, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 64'd0, "DIV -7/2");
        chk("DIV -7/2 const", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, "DIVU");
        chk("DIVU const", result_o, {32'd1, 32'h7FFF_FFFC});
        run_op(3'b110, 32'd3, 32'd7, 64'h10, "MSUBU");
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 64'h1_0000_0000, "MADD");
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, "DIV min/-1");
        run_op(3'b010, 32'h1234, 32'd0, 64'd0, "DIVU by zero");
        run_op(3'b000, 32'd2, 32'd3, 64'd0, "MULTU after div0");
        run_op(3'b011, 32'd5, 32'd0, 64'd0, "DIV by zero");
        run_op(3'b111, 32'h8000_0000, 32'h8000_0000, 64'h5, "MSUB min*min");

        // MUL_STEP=4 instance: MULT -2*3 completes at cycle 9
        @(negedge clk);
        op_i = 3'b001; opa_i = 32'hFFFF_FFFE; opb_i = 32'd3; hilo_i = '0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; opa_i = $urandom; opb_i = $urandom;
        cyc = 1;
        while (!ready4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("STEP4 latency", 64'(cyc), 64'd9);
        chk("STEP4 result", result4, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("STEP4 div_zero", 64'(div_zero4), 64'd0);

        // Randomized operations, with occasional zero divisors
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            rh  = {$urandom, $urandom};
            run_op(rop, ra, rb, rh, $sformatf("rand%0d op%0d", i, rop));
        end

        // Annul a DIV at cycle 10: busy drops at cycle 11, prior result retained
        run_op(3'b010, 32'd100, 32'd7, 64'd0, "DIVU pre-annul");
        prev = model(3'b010, 32'd100, 32'd7, 64'd0);
        @(negedge clk);
        op_i = 3'b011; opa_i = 32'd1000; opb_i = 32'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul busy", 64'(busy_o), 64'd0);
        nready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) nready++;
        end
        chk("annul no ready", 64'(nready), 64'd0);
        chk("annul result kept", result_o, prev[63:0]);
        chk("annul flag kept", 64'(div_zero_o), 64'(prev[64]));

        // Start with annul in IDLE does not start
        op_i = 3'b000; opa_i = 32'd4; opb_i = 32'd4; start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        chk("start+annul busy", 64'(busy_o), 64'd0);
        nready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) nready++;
        end
        chk("start+annul no ready", 64'(nready), 64'd0);

        // Back-to-back: start held through DONE launches the next op directly
        op_i = 3'b000; opa_i = 32'd5; opb_i = 32'd5; hilo_i = '0; start_i = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b first latency", 64'(cyc), 64'd33);
        chk("b2b first result", result_o, 64'd25);
        op_i = 3'b001; opa_i = 32'hFFFF_FFF9; opb_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b busy next", 64'(busy_o), 64'd1);
        chk("b2b ready low", 64'(ready_o), 64'd0);
        e = model(3'b001, 32'hFFFF_FFF9, 32'd9, 64'd0);
        cyc = 1;
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b second latency", 64'(cyc), 64'd33);
        chk("b2b second result", result_o, e[63:0]);

        // Reset at cycle 5 of a MULT discards it
        @(negedge clk);
        op_i = 3'b001; opa_i = 32'd11; opb_i = 32'd13; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 64'(busy_o), 64'd0);
        chk("midrst ready", 64'(ready_o), 64'd0);
        chk("midrst result", result_o, 64'd0);
        chk("midrst div_zero", 64'(div_zero_o), 64'd0);
        nready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) nready++;
        end
        chk("midrst no ready", 64'(nready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
